// File: rtl/pill_pkg.sv
// Shared definitions for the pill dispenser: missed-dose record layout, log FSM states, default log depth.
package pill_pkg;

    localparam int PILL_ID_W = 4;
    localparam int DAY_W     = 7;
    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;

    localparam int SEC_LSB     = 0;
    localparam int MIN_LSB     = SEC_LSB + SEC_W;
    localparam int HOUR_LSB    = MIN_LSB + MIN_W;
    localparam int DAY_LSB     = HOUR_LSB + HOUR_W;
    localparam int PILL_ID_LSB = DAY_LSB + DAY_W;
    localparam int REC_W       = PILL_ID_LSB + PILL_ID_W;

    localparam int LOG_DEPTH = 16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } log_state_e;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [PILL_ID_W-1:0] pill_id,
        input logic [DAY_W-1:0]     day,
        input logic [HOUR_W-1:0]    hour,
        input logic [MIN_W-1:0]     minute,
        input logic [SEC_W-1:0]     second
    );
        return {pill_id, day, hour, minute, second};
    endfunction

endpackage

// File: rtl/log_ram.sv
// Record store for the missed-dose log: one write port, one synchronous read port,
// no reset so it maps onto FPGA block RAM.
module log_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 28
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/missed_dose_log.sv
// Circular missed-dose event log with browse buttons and a DEPTH-cycle clear sweep.
// Build option: define MISSED_LOG_AUTO_NEWEST_EN to jump the view to the newest record on every write.
module missed_dose_log
    import pill_pkg::*;
#(
    parameter int DEPTH = LOG_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = REC_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          log_we,
    input  logic [DW-1:0] log_record,
    input  logic          clear,
    input  logic          btn_next,
    input  logic          btn_prev,
    output logic [DW-1:0] dataFromRAM,
    output logic          entry_valid,
    output logic [AW-1:0] view_index,
    output logic [AW:0]   entry_count,
    output logic          overflow,
    output logic          busy
);

    localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_SWEEP = AW'(DEPTH - 1);

    log_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] view_q, view_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          valid_pipe_q;
    logic          entry_valid_q;
    logic [DW-1:0] data_q;

    logic [AW:0]   count_inc;
    logic [AW:0]   view_inc;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_rdata;

    // Age 0 is the slot just behind the write pointer; the subtraction wraps mod DEPTH.
    assign rd_addr = wr_ptr_q - 1'b1 - view_q;

    log_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        view_d     = view_q;
        sweep_d    = sweep_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        drop_d     = drop_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr_q;
        ram_wdata  = log_record;
        count_inc  = (count_q == FULL) ? FULL : count_q + 1'b1;
        view_inc   = {1'b0, view_q} + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEARING;
                    busy_d     = 1'b1;
                    sweep_d    = '0;
                    overflow_d = 1'b0;
                    drop_d     = 1'b0;
                end else if (log_we) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_inc;
                    if (count_q == FULL) begin
                        overflow_d = 1'b1;
                    end
`ifdef MISSED_LOG_AUTO_NEWEST_EN
                    view_d = '0;
`else
                    // Follow the displayed record as it ages; pinned at the oldest slot once full.
                    view_d = (view_inc < count_inc) ? view_q + 1'b1 : view_q;
`endif
                end else if (count_q != '0 && (btn_next ^ btn_prev)) begin
                    if (btn_next && view_inc < count_q) begin
                        view_d = view_inc[AW-1:0];
                    end else if (btn_prev && view_q != '0) begin
                        view_d = view_q - 1'b1;
                    end
                end
            end
            ST_CLEARING: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_q;
                ram_wdata = '0;
                if (log_we) begin
                    drop_d = 1'b1;
                end
                if (sweep_q == LAST_SWEEP) begin
                    state_d    = ST_IDLE;
                    wr_ptr_d   = '0;
                    count_d    = '0;
                    view_d     = '0;
                    busy_d     = 1'b0;
                    overflow_d = drop_q | log_we;
                    drop_d     = 1'b0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // valid_pipe_q lines the empty flag up with the RAM read latency so the forced zero tracks the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            view_q        <= '0;
            sweep_q       <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
            valid_pipe_q  <= 1'b0;
            entry_valid_q <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            view_q        <= view_d;
            sweep_q       <= sweep_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
            valid_pipe_q  <= (count_q != '0);
            entry_valid_q <= valid_pipe_q;
            data_q        <= valid_pipe_q ? ram_rdata : '0;
        end
    end

    assign dataFromRAM = data_q;
    assign entry_valid = entry_valid_q;
    assign view_index  = view_q;
    assign entry_count = count_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule
